// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer: runs each load/store as a req/ack transaction,
// stalls the pipeline while it is outstanding, and provides a timeout watchdog.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WData_i,
  output logic        Stall_o,
  output logic [31:0] RData_o,
  output logic        MemReq_o,
  output logic        MemWe_o,
  output logic [31:0] MemAddr_o,
  output logic [31:0] MemWData_o,
  input  logic        MemAck_i,
  input  logic [31:0] MemRData_i,
  output logic        Error_o,
  output logic [15:0] StallCnt_o
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [15:0] scnt_q, scnt_d;
  logic        mem_op;
  logic        stall;

  assign mem_op = MemRead_i | MemWrite_i;
  assign stall  = ((state_q == StIdle) && mem_op) || (state_q == StReq);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      StIdle: begin
        if (mem_op) begin
          addr_d  = Addr_i;
          wdata_d = WData_i;
          we_d    = MemWrite_i;
          tcnt_d  = 8'd0;
          state_d = StReq;
        end
      end
      StReq: begin
        // An ack in the final allowed cycle still completes the access cleanly.
        if (MemAck_i) begin
          if (!we_q) begin
            rdata_d = MemRData_i;
          end
          state_d = StDone;
        end else if (tcnt_q == TimeoutLast) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = StDone;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      StDone: begin
        // Inputs here still belong to the instruction that just completed.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    scnt_d = scnt_q;
    if (stall && (scnt_q != 16'hFFFF)) begin
      scnt_d = scnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      tcnt_q  <= 8'd0;
      scnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  // Request is decoded from state so an asynchronous reset drops it immediately.
  assign MemReq_o   = (state_q == StReq);
  assign MemWe_o    = we_q;
  assign MemAddr_o  = addr_q;
  assign MemWData_o = wdata_q;
  assign RData_o    = rdata_q;
  assign Error_o    = err_q;
  assign Stall_o    = stall;
  assign StallCnt_o = scnt_q;

endmodule
